contadores_scanner: RTL and testbench
=====================================

# contadores_scanner

Sweep reader for the counter RAM. On a start pulse it walks every counter address from 0 to 2^ADDR_W-1 and reads each count. It emits one (address, count) pair per address on a valid/ready stream and can optionally clear each counter after it is read. It drives the counter RAM's address, read and reset controls, and sits between the RAM and the downstream reporting logic.

## Interface
Parameters:
- ADDR_W, 6, counter RAM address width; the scan covers 2^ADDR_W counters.
- COUNT_W, 4, counter width.

Ports:
- clk  in  1  sole clock; everything updates on the rising edge.
- gen_reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a scan; ignored while busy=1.
- clear_en  in  1  sampled together with start; 1 selects read-and-clear.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the scan completes.
- ram_adress  out  ADDR_W  counter RAM address.
- ram_count_read  out  1  RAM read strobe.
- ram_write_enable  out  1  RAM write strobe; asserted only in CLEAR.
- ram_count_reset  out  1  RAM counter clear; asserted only in CLEAR, together with ram_write_enable.
- ram_count_in  in  COUNT_W  RAM read data; valid one cycle after the read strobe.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_adress  out  ADDR_W  address of the emitted counter.
- out_count  out  COUNT_W  value of the emitted counter.
- sum_out  out  ADDR_W+COUNT_W  total of all counts read in the last scan; stable from done onward.

## Operation
The block is a state machine with states IDLE, READ, WAIT, EMIT, CLEAR and DONE.
- **IDLE:** on start=1, latch clear_en, set addr=0, clear sum_out, go to READ.
- **READ:** ram_adress=addr, ram_count_read=1; go to WAIT.
- **WAIT:** register ram_count_in into out_count and addr into out_adress; add the count to sum_out (zero-extended, no overflow possible); go to EMIT.
- **EMIT:** out_valid=1; out_adress and out_count are held until out_valid&&out_ready. On transfer, go to CLEAR if the latched clear_en=1, else ADVANCE.
- **CLEAR:** ram_adress=addr, ram_write_enable=1, ram_count_reset=1 for exactly one cycle, then ADVANCE.
- **ADVANCE** (a transition, not a state): if addr==2^ADDR_W-1 go to DONE, else addr+1 and go to READ. The address never wraps within a scan.
- **DONE:** done=1 for one cycle, busy=0 from the next cycle, return to IDLE.

Rules that apply in every state:
- All RAM strobes are 0 outside the states listed above.
- ram_write_enable is never 1 without ram_count_reset, so the scanner never increments a counter.
- out_valid never drops before a transfer.
- start arriving in the same cycle as done is ignored; it is accepted only in IDLE.

## Timing
- **Reset values:** gen_reset=1 forces IDLE and all outputs to 0 (busy, done, strobes, out_valid, ram_adress, out_adress, out_count, sum_out) on the next edge.
- **Reset mid-scan:** no clear strobe is issued after reset; the scan is abandoned.
- **Latency:** start is sampled at edge E0. busy=1 and READ follow E0. out_valid=1 follows E2.
- **Per-address cost** with out_ready held at 1: 3 cycles without clear, 4 with clear.
- **Full scan** with ADDR_W=6 and out_ready=1: 192 cycles (no clear) or 256 cycles (clear) from start acceptance to the done pulse. Each cycle of backpressure extends this by one.
- **Clear ordering:** the clear of address a always occurs after address a is emitted and before address a+1 is read.

## Configuration
- **CONTADORES_SCANNER_SKIP_ZERO_EN defined:** in WAIT, a count of 0 skips EMIT and CLEAR and goes straight to ADVANCE. Zero counters are not emitted, and that address costs 2 cycles. sum_out is unaffected.
- **Not defined:** every address is emitted, zeros included.

## Test plan
- Preload counters 1=2, 2=3, 4=1, 8=1, others 0; start with clear_en=0 and out_ready=1. Expect 64 transfers in address order with those counts, sum_out=7, done exactly 192 cycles after acceptance, and RAM contents unchanged.
- Same preload, start with clear_en=1. Expect the same stream, one write_enable+count_reset pulse per address, and all counters 0 afterwards; a second scan emits all zeros with sum_out=0.
- Drop out_ready for 5 cycles while address 2 is in EMIT. Expect out_valid held, out_adress=2 and out_count=3 stable, no RAM strobe during the stall, and done delayed by 5 cycles.
- Pulse start at address 10 mid-scan. Expect it ignored; the scan continues and completes normally.
- Assert gen_reset while in CLEAR at address 8 with clear_en=1. Expect all outputs 0 next cycle, counters 9..63 untouched, and a fresh start scanning from 0.
- With CONTADORES_SCANNER_SKIP_ZERO_EN defined and the first preload, expect exactly 4 transfers (addresses 1, 2, 4, 8) and sum_out=7.

Source files
------------

// File: rtl/contadores_scanner.sv
// contadores_scanner: sweeps the counter RAM from address 0 to the top, streaming (address, count) pairs with optional read-and-clear.
// Define CONTADORES_SCANNER_SKIP_ZERO_EN to drop zero counters from the stream.
module contadores_scanner #(
    parameter int ADDR_W  = 6,
    parameter int COUNT_W = 4
) (
    input  logic                      clk,
    input  logic                      gen_reset,
    input  logic                      start,
    input  logic                      clear_en,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         ram_adress,
    output logic                      ram_count_read,
    output logic                      ram_write_enable,
    output logic                      ram_count_reset,
    input  logic [COUNT_W-1:0]        ram_count_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_adress,
    output logic [COUNT_W-1:0]        out_count,
    output logic [ADDR_W+COUNT_W-1:0] sum_out
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, CLEAR, DONE} state_t;
    state_t                    state_q;
    logic [ADDR_W-1:0]         addr_q, out_adress_q;
    logic [COUNT_W-1:0]        out_count_q;
    logic [ADDR_W+COUNT_W-1:0] sum_q;
    logic                      clr_q, busy_q, done_q, rd_q, wr_q, valid_q;
    logic                      skip_d, adv_d;
`ifdef CONTADORES_SCANNER_SKIP_ZERO_EN
    assign skip_d = (state_q == WAIT) && (ram_count_in == '0);
`else
    assign skip_d = 1'b0;
`endif
    // Single advance point: the address only moves after emit (or clear) of the current one.
    assign adv_d = skip_d || (state_q == CLEAR) || (state_q == EMIT && out_ready && !clr_q);
    always_ff @(posedge clk) begin
        if (gen_reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            out_adress_q <= '0;
            out_count_q  <= '0;
            sum_q        <= '0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    clr_q   <= clear_en;
                    addr_q  <= '0;
                    sum_q   <= '0;
                    busy_q  <= 1'b1;
                    rd_q    <= 1'b1;
                    state_q <= READ;
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    out_count_q  <= ram_count_in;
                    out_adress_q <= addr_q;
                    sum_q        <= sum_q + (ADDR_W+COUNT_W)'(ram_count_in);
                    valid_q      <= !skip_d;
                    state_q      <= EMIT;
                end
                EMIT: if (out_ready) begin
                    valid_q <= 1'b0;
                    if (clr_q) begin
                        wr_q    <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (adv_d) begin
                if (addr_q == {ADDR_W{1'b1}}) begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end else begin
                    addr_q  <= addr_q + ADDR_W'(1);
                    rd_q    <= 1'b1;
                    state_q <= READ;
                end
            end
        end
    end
    assign busy             = busy_q;
    assign done             = done_q;
    assign ram_adress       = addr_q;
    assign ram_count_read   = rd_q;
    assign ram_write_enable = wr_q;
    assign ram_count_reset  = wr_q;
    assign out_valid        = valid_q;
    assign out_adress       = out_adress_q;
    assign out_count        = out_count_q;
    assign sum_out          = sum_q;
endmodule

// File: tb/tb_contadores_scanner.sv
// tb_contadores_scanner: directed scans against a counter RAM model and a stream/sum/timing model of the scanner.
module tb_contadores_scanner;
    localparam int AW = 6;
    localparam int CW = 4;
    localparam int N  = 1 << AW;
`ifdef CONTADORES_SCANNER_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    typedef struct {logic [AW-1:0] a; logic [CW-1:0] c;} item_t;

    logic clk = 1'b0, gen_reset = 1'b1, start = 1'b0, clear_en = 1'b0, out_ready = 1'b1;
    logic busy, done, ram_count_read, ram_write_enable, ram_count_reset, out_valid;
    logic [AW-1:0] ram_adress, out_adress;
    logic [CW-1:0] ram_count_in = '0, out_count;
    logic [AW+CW-1:0] sum_out;
    logic [CW-1:0] mem [N];
    logic [CW-1:0] pre [N];
    logic [CW-1:0] p1 [N];
    logic [CW-1:0] p2 [N];
    logic load = 1'b0;
    int checks = 0, errors = 0, cyc = 0, clr_pulses = 0, ntx = 0, last_tx = -1;
    bit chk_en = 1'b0;
    item_t expq[$];

    always #5 clk = ~clk;

    contadores_scanner #(.ADDR_W(AW), .COUNT_W(CW)) dut (
        .clk(clk), .gen_reset(gen_reset), .start(start), .clear_en(clear_en),
        .busy(busy), .done(done), .ram_adress(ram_adress), .ram_count_read(ram_count_read),
        .ram_write_enable(ram_write_enable), .ram_count_reset(ram_count_reset),
        .ram_count_in(ram_count_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_adress(out_adress), .out_count(out_count), .sum_out(sum_out)
    );

    // Counter RAM: registered read, clear-on-strobe, bulk preload.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= pre[i];
        end else begin
            if (ram_count_read) ram_count_in <= mem[ram_adress];
            if (ram_write_enable && ram_count_reset) mem[ram_adress] <= '0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic pv = 1'b0, pr = 1'b1;
    logic [AW-1:0] pa = '0;
    logic [CW-1:0] pc = '0;
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_eq_rst", ram_write_enable, ram_count_reset);
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_adr", out_adress, pa);
                chk("hold_cnt", out_count, pc);
                chk("stall_strobes", {ram_count_read, ram_write_enable}, 0);
            end
            if (ram_write_enable) begin
                clr_pulses++;
                chk("clr_adr", ram_adress, last_tx);
            end
            if (out_valid && out_ready) begin
                chk("tx_expected", expq.size() > 0, 1);
                if (expq.size() > 0) begin
                    chk("tx_adr", out_adress, expq[0].a);
                    chk("tx_cnt", out_count, expq[0].c);
                    void'(expq.pop_front());
                end
                ntx++;
                last_tx = out_adress;
            end
        end
        pv = out_valid; pr = out_ready; pa = out_adress; pc = out_count;
    end

    task automatic load_mem(input logic [CW-1:0] src [N]);
        pre = src;
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic build_model(input bit clr, output int cost, output int total);
        item_t it;
        cost = 0; total = 0;
        expq.delete();
        for (int a = 0; a < N; a++) begin
            total += int'(mem[a]);
            if (SKIP && mem[a] == '0) cost += 2;
            else begin
                it.a = AW'(a); it.c = mem[a];
                expq.push_back(it);
                cost += clr ? 4 : 3;
            end
        end
    endtask

    task automatic zero_outs(input string tag);
        chk({tag, "_flags"}, {busy, done, ram_count_read, ram_write_enable, ram_count_reset, out_valid}, 0);
        chk({tag, "_ram_adr"}, ram_adress, 0);
        chk({tag, "_out_adr"}, out_adress, 0);
        chk({tag, "_out_cnt"}, out_count, 0);
        chk({tag, "_sum"}, sum_out, 0);
    endtask

    task automatic run_scan(input bit clr, input int extra, input int lit_cyc, input int lit_sum, input int lit_n);
        int exp_c, exp_s, c0;
        bit got = 1'b0;
        build_model(clr, exp_c, exp_s);
        ntx = 0; clr_pulses = 0; last_tx = -1;
        @(posedge clk); #1 start = 1'b1; clear_en = clr;
        @(posedge clk); #1 start = 1'b0; clear_en = 1'b0; c0 = cyc;
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
        chk("done_seen", got, 1);
        chk("scan_cycles", cyc - c0, exp_c + extra);
        chk("scan_cycles_lit", cyc - c0, lit_cyc);
        chk("sum", sum_out, exp_s);
        chk("sum_lit", sum_out, lit_sum);
        chk("tx_count_lit", ntx, lit_n);
        chk("all_emitted", expq.size(), 0);
        @(negedge clk);
        chk("busy_low", busy, 0);
        chk("done_low", done, 0);
        chk("sum_stable", sum_out, exp_s);
    endtask

    task automatic stall_at(input int a, input int n);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_adress == AW'(a)) begin
                out_ready = 1'b0;
                repeat (n) @(posedge clk);
                #1 out_ready = 1'b1;
                return;
            end
        end
        chk("stall_point_seen", 0, 1);
    endtask

    task automatic start_at(input int a);
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (out_valid && out_adress == AW'(a)) begin
                start = 1'b1; clear_en = 1'b1;
                @(posedge clk); #1 start = 1'b0; clear_en = 1'b0;
                return;
            end
        end
        chk("start_point_seen", 0, 1);
    endtask

    function automatic int diff_count(input logic [CW-1:0] ref_m [N], input int lo);
        int d = 0;
        for (int i = lo; i < N; i++) if (mem[i] !== ref_m[i]) d++;
        return d;
    endfunction

    initial begin
        int c, s, d;
        bit got;
        for (int i = 0; i < N; i++) begin
            p1[i] = '0;
            p2[i] = CW'(i % 16);
        end
        p1[1] = 4'd2; p1[2] = 4'd3; p1[4] = 4'd1; p1[8] = 4'd1;
        load_mem(p1);
        @(negedge clk);
        zero_outs("reset");
        @(posedge clk); #1 gen_reset = 1'b0;
        chk_en = 1'b1;

        run_scan(0, 0, SKIP ? 132 : 192, 7, SKIP ? 4 : 64);
        chk("no_clear_pulses", clr_pulses, 0);
        chk("mem_unchanged", diff_count(p1, 0), 0);

        run_scan(1, 0, SKIP ? 136 : 256, 7, SKIP ? 4 : 64);
        chk("clear_pulses", clr_pulses, SKIP ? 4 : 64);
        for (int i = 0; i < N; i++) pre[i] = '0;
        chk("mem_cleared", diff_count(pre, 0), 0);
        run_scan(0, 0, SKIP ? 128 : 192, 0, SKIP ? 0 : 64);

        load_mem(p1);
        fork stall_at(2, 5); join_none
        run_scan(0, 5, SKIP ? 137 : 197, 7, SKIP ? 4 : 64);

        fork start_at(10); join_none
        run_scan(0, 0, SKIP ? 132 : 192, 7, SKIP ? 4 : 64);
        chk("mem_after_ignored_start", diff_count(p1, 0), 0);

        load_mem(p2);
        build_model(1, c, s);
        @(posedge clk); #1 start = 1'b1; clear_en = 1'b1;
        @(posedge clk); #1 start = 1'b0; clear_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(posedge clk); #1;
            got = ram_write_enable && ram_adress == AW'(8);
        end
        chk("clear8_seen", got, 1);
        chk_en = 1'b0;
        gen_reset = 1'b1;
        @(posedge clk); #1 gen_reset = 1'b0;
        @(negedge clk);
        zero_outs("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_strobe_after_reset", {ram_count_read, ram_write_enable, ram_count_reset}, 0);
        end
        chk("untouched_9_63", diff_count(p2, 9), 0);
        d = 0;
        for (int i = 0; i < 9; i++) if (mem[i] !== '0) d++;
        chk("cleared_0_8", d, 0);
        pv = 1'b0; pr = 1'b1;
        chk_en = 1'b1;
        run_scan(0, 0, SKIP ? 180 : 192, 444, SKIP ? 52 : 64);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
